rst_sequencer: RTL and testbench

Reset sequencer and watchdog for the RISC5 system. It sits directly behind the clock/reset generator and consumes its synchronous reset. It releases a set of per-subsystem resets in a fixed order: the memory controller first, then the CPU, then peripherals, each release gated by memory-ready and programmable gaps. It also restarts the whole sequence on a software reset request or a watchdog expiry, and records the cause of the last reset.

---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/rst_wdog.sv | 49 ++++
 rtl/rst_sequencer.sv | 131 +++++++++++++
 tb/tb_rst_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the RISC5 reset sequencer and its watchdog.
package rst_seq_pkg;

    // Sequencer phases: hold everything in reset, wait for memory, release
    // the remaining stages one by one, then run with the watchdog armed.
    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_STAGE    = 2'd2,
        ST_RUN      = 2'd3
    } seq_state_e;

    // Encoding of the last reset cause; 2'b11 is never produced.
    localparam logic [1:0] CAUSE_EXT  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;

    // Elaboration-time helper used to size the shared phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : rst_seq_pkg

// File: rtl/rst_wdog.sv
// Watchdog for the reset sequencer. Counts RUN cycles while enabled and
// raises a one-cycle expire pulse when the count reaches the programmed limit
// without a kick in the same cycle. A limit of zero disables it.
module rst_wdog #(
    parameter int WDOG_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              wdog_en,
    input  logic              wdog_kick,
    input  logic [WDOG_W-1:0] wdog_limit,
    output logic              expire
);

    logic [WDOG_W-1:0] wcnt_q;
    logic [WDOG_W-1:0] wcnt_d;
    logic              active;

    // Expiry decision and next count; a kick always wins over the increment,
    // and the count returns to zero whenever the watchdog is idle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        active = run && wdog_en && (wdog_limit != '0);
        expire = 1'b0;
        wcnt_d = wcnt_q;
        if (!active || wdog_kick) begin
            wcnt_d = '0;
        end else if (wcnt_q == wdog_limit) begin
            // Expiry restarts the sequence, so the count never reaches wrap-around.
            expire = 1'b1;
            wcnt_d = '0;
        end else begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous: it is only seen on a clock edge, like any other input.
        if (rst) begin
            // NOTE: sequential state uses <= so all registers update from pre-edge values.
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

endmodule : rst_wdog

// File: rtl/rst_sequencer.sv
// Reset sequencer for the RISC5 system. Releases per-subsystem resets in a
// fixed order (memory controller, CPU, peripherals), gated by mem_ready and
// fixed gaps, restarts on software request or watchdog expiry, and records
// the cause of the last reset. All outputs are registered.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int HOLD      = 8,
    parameter int STAGE_DLY = 16,
    parameter int WDOG_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ready,
    input  logic              sw_rst_req,
    input  logic              wdog_en,
    input  logic              wdog_kick,
    input  logic [WDOG_W-1:0] wdog_limit,
    output logic [STAGES-1:0] rst_out,
    output logic [1:0]        cause,
    output logic              busy
);

    // The phase counter only ever needs to reach max(HOLD, STAGE_DLY) - 1.
    localparam int CNT_W = $clog2(max_int(HOLD, STAGE_DLY) + 1);
    // Index of the next stage bit waiting to be released.
    localparam int STG_W = $clog2(STAGES + 1);

    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]  STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [STG_W-1:0]  STG_FIRST  = STG_W'(1);
    localparam logic [STG_W-1:0]  STG_FINAL  = STG_W'(STAGES - 1);
    localparam logic [STAGES-1:0] STG_ONE    = STAGES'(1);

    seq_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STG_W-1:0]  stage_q;
    logic [STAGES-1:0] rst_out_q;
    logic [1:0]        cause_q;
    logic              busy_q;

    logic              run;
    logic              wdog_expire;
    logic              restart;
    logic [1:0]        restart_cause;

    assign run = (state_q == ST_RUN);

    rst_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .wdog_en    (wdog_en),
        .wdog_kick  (wdog_kick),
        .wdog_limit (wdog_limit),
        .expire     (wdog_expire)
    );

    // Internal restart request; watchdog expiry outranks a software request.
    always_comb begin
        restart       = wdog_expire || sw_rst_req;
        restart_cause = wdog_expire ? CAUSE_WDOG : CAUSE_SW;
    end

    // Sequencer FSM with registered reset outputs, cause and busy.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            // Any trigger restarts the full HOLD period; there is no partial resume.
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            stage_q   <= STG_FIRST;
            rst_out_q <= '1;
            busy_q    <= 1'b1;
            cause_q   <= rst ? CAUSE_EXT : restart_cause;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q      <= ST_WAIT_MEM;
                        rst_out_q[0] <= 1'b0;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_ready) begin
                        cnt_q <= '0;
                        if (STAGES == 1) begin
                            // Only the memory controller reset exists: done.
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_STAGE;
                            stage_q <= STG_FIRST;
                        end
                    end
                end
                ST_STAGE: begin
                    // mem_ready is deliberately ignored from here on.
                    if (cnt_q == STAGE_LAST) begin
                        cnt_q     <= '0;
                        rst_out_q <= rst_out_q & ~(STG_ONE << stage_q);
                        if (stage_q == STG_FINAL) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Fully released; only a trigger leaves this state.
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign rst_out = rst_out_q;
    assign cause   = cause_q;
    assign busy    = busy_q;

endmodule : rst_sequencer

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with STAGES=3, HOLD=8, STAGE_DLY=16,
// WDOG_W=8. Edge numbers are counted from the edge that sampled the trigger
// (edge 0); expected outputs come from the documented release schedule.
module tb_rst_sequencer;
    import rst_seq_pkg::*;

    localparam int STAGES    = 3;
    localparam int HOLD      = 8;
    localparam int STAGE_DLY = 16;
    localparam int WDOG_W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_ready;
    logic              sw_rst_req;
    logic              wdog_en;
    logic              wdog_kick;
    logic [WDOG_W-1:0] wdog_limit;
    logic [STAGES-1:0] rst_out;
    logic [1:0]        cause;
    logic              busy;

    int n_pass    = 0;
    int n_total   = 0;
    int inv_viol  = 0;

    rst_sequencer #(
        .STAGES    (STAGES),
        .HOLD      (HOLD),
        .STAGE_DLY (STAGE_DLY),
        .WDOG_W    (WDOG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ready  (mem_ready),
        .sw_rst_req (sw_rst_req),
        .wdog_en    (wdog_en),
        .wdog_kick  (wdog_kick),
        .wdog_limit (wdog_limit),
        .rst_out    (rst_out),
        .cause      (cause),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Ordering invariant: a released stage implies all earlier stages released.
    always @(negedge clk) begin
        for (int i = 1; i < STAGES; i++) begin
            if (rst_out[i] === 1'b0 && rst_out[i-1] !== 1'b0) inv_viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks edges 1..last_edge after a trigger at edge 0 and compares every
    // edge against the release schedule. mem_ready is first high at mem_edge
    // and pulled low again over [drop_from, drop_to].
    task automatic run_schedule(input string name, input int mem_edge,
                                input int drop_from, input int drop_to,
                                input int last_edge, input logic [1:0] exp_cause);
        logic [STAGES-1:0] exp_rst;
        logic              exp_busy;
        int                m;
        m = (mem_edge > HOLD + 1) ? mem_edge : HOLD + 1;
        for (int e = 1; e <= last_edge; e++) begin
            mem_ready = (e >= mem_edge) && !(e >= drop_from && e <= drop_to);
            tick();
            exp_rst[0] = (e < HOLD);
            for (int k = 1; k < STAGES; k++) exp_rst[k] = (e < m + k * STAGE_DLY);
            exp_busy = (e < m + (STAGES - 1) * STAGE_DLY);
            n_total++;
            if ({rst_out, busy, cause} !== {exp_rst, exp_busy, exp_cause})
                $display("FAIL %s edge %0d: got rst_out=%b busy=%b cause=%b, want rst_out=%b busy=%b cause=%b",
                         name, e, rst_out, busy, cause, exp_rst, exp_busy, exp_cause);
            else
                n_pass++;
        end
    endtask

    // Compares the outputs on the edge that sampled a trigger.
    task automatic expect_trigger(input string name, input logic [1:0] exp_cause);
        n_total++;
        if ({rst_out, busy, cause} !== {3'b111, 1'b1, exp_cause})
            $display("FAIL %s trigger edge: got rst_out=%b busy=%b cause=%b, want rst_out=111 busy=1 cause=%b",
                     name, rst_out, busy, cause, exp_cause);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; sw_rst_req = 1'b0;
        wdog_en = 1'b0; wdog_kick = 1'b0; wdog_limit = '0;
        repeat (3) tick();
        expect_trigger("reset", CAUSE_EXT);
        rst = 1'b0;
    endtask

    task automatic test_powerup();
        run_schedule("powerup", 1, 0, -1, 45, CAUSE_EXT);
    endtask

    task automatic test_mem_delay();
        mem_ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        expect_trigger("mem_delay", CAUSE_EXT);
        run_schedule("mem_delay", 100, 104, 110, 135, CAUSE_EXT);
    endtask

    task automatic test_sw_reset();
        sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
        expect_trigger("sw", CAUSE_SW);
        run_schedule("sw", 1, 0, -1, 45, CAUSE_SW);
    endtask

    task automatic test_wdog_expire();
        wdog_limit = 8'd20; wdog_en = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            tick();
            n_total++;
            if (i < 21) begin
                if ({rst_out, busy, cause} !== {3'b000, 1'b0, CAUSE_SW})
                    $display("FAIL wdog_run edge %0d: got rst_out=%b busy=%b cause=%b, want 000/0/01",
                             i, rst_out, busy, cause);
                else n_pass++;
            end else begin
                if ({rst_out, busy, cause} !== {3'b111, 1'b1, CAUSE_WDOG})
                    $display("FAIL wdog_expire edge %0d: got rst_out=%b busy=%b cause=%b, want 111/1/10",
                             i, rst_out, busy, cause);
                else n_pass++;
            end
        end
        wdog_en = 1'b0;
        run_schedule("wdog_restart", 1, 0, -1, 45, CAUSE_WDOG);
    endtask

    task automatic test_wdog_kick();
        int resets = 0;
        wdog_limit = 8'd20; wdog_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wdog_kick = (i % 15 == 14);
            tick();
            if (busy !== 1'b0 || rst_out !== 3'b000) resets++;
        end
        wdog_kick = 1'b0; wdog_en = 1'b0;
        n_total++;
        if (resets !== 0)
            $display("FAIL wdog_kick: got %0d reset cycles in 1000, want 0", resets);
        else n_pass++;
    endtask

    // A kick in the very cycle wcnt equals the limit must suppress expiry.
    task automatic test_kick_boundary();
        wdog_limit = 8'd5; wdog_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            wdog_kick = (i == 6);
            tick();
            if (i == 6 || i == 11 || i == 12) begin
                n_total++;
                if (rst_out !== ((i == 12) ? 3'b111 : 3'b000))
                    $display("FAIL kick_boundary edge %0d: got rst_out=%b, want %b",
                             i, rst_out, (i == 12) ? 3'b111 : 3'b000);
                else n_pass++;
            end
        end
        wdog_kick = 1'b0; wdog_en = 1'b0;
        run_schedule("kick_restart", 1, 0, -1, 45, CAUSE_WDOG);
    endtask

    task automatic test_wdog_disabled();
        int resets = 0;
        wdog_limit = '0; wdog_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy !== 1'b0) resets++;
        end
        wdog_en = 1'b0;
        n_total++;
        if (resets !== 0)
            $display("FAIL wdog_limit0: got %0d busy cycles in 300, want 0", resets);
        else n_pass++;
    endtask

    task automatic test_prio_wdog_sw();
        wdog_limit = 8'd5; wdog_en = 1'b1;
        repeat (5) tick();
        sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
        wdog_en = 1'b0;
        expect_trigger("prio_wdog_sw", CAUSE_WDOG);
        // Stop in the middle of STAGE for the next scenario.
        run_schedule("prio_wdog_sw", 1, 0, -1, 20, CAUSE_WDOG);
    endtask

    task automatic test_prio_rst_sw();
        rst = 1'b1; sw_rst_req = 1'b1; tick();
        rst = 1'b0; sw_rst_req = 1'b0;
        expect_trigger("prio_rst_sw", CAUSE_EXT);
        run_schedule("prio_rst_sw", 1, 0, -1, 45, CAUSE_EXT);
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_mem_delay();
        test_sw_reset();
        test_wdog_expire();
        test_wdog_kick();
        test_kick_boundary();
        test_wdog_disabled();
        test_prio_wdog_sw();
        test_prio_rst_sw();
        n_total++;
        if (inv_viol !== 0)
            $display("FAIL ordering_invariant: got %0d violating cycles, want 0", inv_viol);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rst_sequencer
